// File: rtl/alu32_arb2.sv
// Two-requester round-robin front end for a shared 32-bit ALU: grants one
// request at a time, executes it in one cycle and returns a registered result.
module alu32_arb2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_c,
  output logic             rsp_z,
  output logic             rsp_n,
  output logic             rsp_v
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_XNOR = 3'b100,
    OP_ADD  = 3'b101,
    OP_SUB  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_c_q, rsp_c_d;
  logic             rsp_z_q, rsp_z_d;
  logic             rsp_n_q, rsp_n_d;
  logic             rsp_v_q, rsp_v_d;

  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;

  logic             gnt0, gnt1, accept;
  logic [WIDTH-1:0] b_eff, alu_res;
  logic [WIDTH:0]   sum;
  logic             alu_c, alu_v, is_sub;

  // When both requesters are valid, the one not served last wins.
  assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready = (state_q == IDLE) & gnt0 & reset_n;
  assign req1_ready = (state_q == IDLE) & gnt1 & reset_n;
  assign accept     = req0_ready | req1_ready;

  // NOTE: operand latches carry no reset; they are only read after an accept
  // has loaded them, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= req1_ready ? op_e'(req1_op) : op_e'(req0_op);
      a_q  <= req1_ready ? req1_a : req0_a;
      b_q  <= req1_ready ? req1_b : req0_b;
      id_q <= req1_ready;
    end
  end

  // Subtraction reuses the adder as A + ~B + 1, so carry out means A >= B.
  assign is_sub = (op_q == OP_SUB);
  assign b_eff  = is_sub ? ~b_q : b_q;
  assign sum    = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_NOT:  alu_res = ~a_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_XNOR: alu_res = ~(a_q ^ b_q);
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_PASS: alu_res = b_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_c_d      = rsp_c_q;
    rsp_z_d      = rsp_z_q;
    rsp_n_d      = rsp_n_q;
    rsp_v_d      = rsp_v_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = EXEC;
          last_grant_d = req1_ready;
        end
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = alu_res;
        rsp_c_d     = alu_c;
        rsp_z_d     = (alu_res == '0);
        rsp_n_d     = alu_res[WIDTH-1];
        rsp_v_d     = alu_v;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_c_q      <= 1'b0;
      rsp_z_q      <= 1'b0;
      rsp_n_q      <= 1'b0;
      rsp_v_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_c_q      <= rsp_c_d;
      rsp_z_q      <= rsp_z_d;
      rsp_n_q      <= rsp_n_d;
      rsp_v_q      <= rsp_v_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_n     = rsp_n_q;
  assign rsp_v     = rsp_v_q;

endmodule

// File: doc/alu32_arb2.md
Name: alu32_arb2

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 32-bit ALU datapath (bitwise INV/AND/OR/XOR/XNOR plus ADD/SUB).
- Each requester submits an op and two operands over a valid/ready handshake.
- The block grants one request, latches the operands, executes on the shared unit, then presents a registered result and flags with the requester ID over a valid/ready response channel.
- It sits between the register-file read ports of two issue sources and the single ALU instance.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_op  input  3  requester 0 opcode.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req1_valid  input  1  requester 1 has an operation pending.
- req1_ready  output  1  requester 1 accepted this cycle.
- req1_op  input  3  requester 1 opcode.
- req1_a  input  WIDTH  requester 1 operand A.
- req1_b  input  WIDTH  requester 1 operand B.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  requester that owns the result.
- rsp_data  output  WIDTH  result.
- rsp_c  output  1  carry out (ADD); not-borrow (SUB); 0 otherwise.
- rsp_z  output  1  rsp_data == 0.
- rsp_n  output  1  rsp_data[WIDTH-1].
- rsp_v  output  1  signed overflow (ADD/SUB only, else 0).

Behaviour:
- Opcodes:
  - 000 NOT A
  - 001 A AND B
  - 010 A OR B
  - 011 A XOR B
  - 100 A XNOR B
  - 101 A+B
  - 110 A-B, computed as A+~B+1
  - 111 pass B
- Arithmetic is modulo 2^WIDTH.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the single valid requester.
  - If both are valid, grant = NOT last_grant (round robin).
  - reqK_ready = (state==IDLE) & grantK & reqK_valid & reset_n. It is combinational, and at most one ready is high.
  - On handshake, latch op/a/b/id into internal registers, set last_grant=id, go to EXEC.
  - No valid: stay in IDLE.
- EXEC (1 cycle):
  - Compute from the latched operands.
  - Register rsp_data, flags and rsp_id; set rsp_valid=1; go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: clear rsp_valid and go to IDLE.
  - No new request is accepted in that same cycle.
- Latency: handshake in cycle T, rsp_valid=1 from cycle T+2. Minimum issue interval is 3 cycles.
- Requester inputs are ignored outside the IDLE handshake cycle. Operand changes after acceptance do not affect the result.
- rsp_ready while rsp_valid=0 is ignored.
- Reset (asynchronous, reset_n low):
  - state=IDLE, last_grant=1 (requester 0 has first priority).
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_c=rsp_z=rsp_n=rsp_v=0.
  - Both ready outputs forced 0 while reset_n is low.
- Reset mid-operation (EXEC or RESP) discards the in-flight op; no response is produced after release.
- Flag rules:
  - ADD: c = carry out of the MSB.
  - SUB: c = 1 when A >= B unsigned.
  - v = (A[msb]==B'[msb]) & (R[msb]!=A[msb]), where B' = B for ADD and ~B for SUB.
  - z and n are valid for every op.

Test Plan:
- Single request: req0 ADD a=0x7FFFFFFF b=0x00000001 -> rsp at T+2, rsp_id=0, data=0x80000000, v=1, n=1, c=0, z=0.
- Simultaneous requests after reset, both held valid: req0 SUB 5-5 and req1 XNOR 0xFFFF0000,0x0F0F0F0F.
  - First grant goes to req0: data=0, z=1, c=1.
  - After rsp_ready, next grant goes to req1: data=0x0F0FF0F0, id=1.
  - Subsequent grants alternate 0,1,0.
- Backpressure: hold rsp_ready=0 for 5 cycles with a pending result -> rsp_valid and rsp_* stay stable, both req_ready=0, then release completes.
- Bitwise sweep: opcodes 000–100 and 111 on a=0xA5A5A5A5, b=0x0F0F0F0F.
  - Expected: 0x5A5A5A5A, 0x05050505, 0xAFAFAFAF, 0xAAAAAAAA, 0x55555555, 0x0F0F0F0F.
  - c=v=0 for all.
- Reset mid-RESP: assert reset_n=0 -> rsp_valid=0 immediately (asynchronous). After release, req1 alone valid -> granted in the first IDLE cycle.
- Operand change after accept: req0 ADD 1+1, then change a to 100 during EXEC -> data=2.
